// File: rtl/biriscv_tcm_arb_pkg.sv
// Shared types and constants for the biriscv TCM arbiter.
package biriscv_tcm_arb_pkg;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam int unsigned TAG_W = 11;

  // One entry per in-flight downstream request: who asked, which 32-bit half, and its tag.
  typedef struct packed {
    logic             src;
    logic             addr2;
    logic [TAG_W-1:0] tag;
  } fifo_entry_t;

  // Place a 4-bit word strobe into the correct half of the 8-bit lane strobe.
  function automatic logic [7:0] lane_strobe(input logic addr2, input logic [3:0] wr);
    return addr2 ? {wr, 4'b0000} : {4'b0000, wr};
  endfunction

endpackage

// File: rtl/biriscv_tcm_arb_fifo.sv
// Outstanding-response FIFO: remembers the source of each in-flight request so responses,
// which return in order, can be steered back. Storage is reset-less; only pointers reset.
module biriscv_tcm_arb_fifo
  import biriscv_tcm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t data_i,
  input  logic        pop_i,
  output fifo_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  fifo_entry_t     mem_q [DEPTH];
  logic            do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push while full is only legal when the same cycle's pop frees the slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/biriscv_tcm_arbiter.sv
// Round-robin arbiter sharing one 64-bit TCM port between instruction fetch and data.
// Optional performance counters are enabled by defining BIRISCV_TCM_ARB_PERF_EN.
module biriscv_tcm_arbiter
  import biriscv_tcm_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_i_rd_i,
  input  logic [ADDR_W-1:0] mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [63:0]       mem_i_inst_o,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic [ADDR_W-1:0] mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o,
  output logic              ram_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wr_o,
  output logic [63:0]       ram_data_o,
  input  logic              ram_accept_i,
  input  logic              ram_ack_i,
  input  logic              ram_error_i,
  input  logic [63:0]       ram_data_i,
`ifdef BIRISCV_TCM_ARB_PERF_EN
  output logic [31:0]       perf_i_grants_o,
  output logic [31:0]       perf_d_grants_o,
  output logic [31:0]       perf_stall_o,
`endif
  output logic              spurious_o
);

  logic        i_req, d_req;
  logic        grant_i, grant_d;
  logic        handshake;
  logic        last_d_q, last_d_d;
  logic        spurious_q, spurious_d;
  logic        fifo_full, fifo_empty, fifo_pop;
  fifo_entry_t push_entry, head_entry;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^mem_d_addr_i[1:0];

  assign i_req = mem_i_rd_i;
  assign d_req = mem_d_rd_i | (|mem_d_wr_i);

  // Grant: on a tie the port not granted last wins; nothing is granted while the FIFO is full.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!fifo_full) begin
      if (i_req && d_req) begin
        grant_i = last_d_q;
        grant_d = ~last_d_q;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign ram_req_o      = grant_i | grant_d;
  assign handshake      = ram_req_o & ram_accept_i;
  assign mem_i_accept_o = grant_i & ram_accept_i & ~fifo_full;
  assign mem_d_accept_o = grant_d & ram_accept_i & ~fifo_full;

  // Downstream request drive for whichever port holds the grant.
  always_comb begin
    ram_addr_o = '0;
    ram_wr_o   = '0;
    ram_data_o = '0;
    if (grant_d) begin
      ram_addr_o = {mem_d_addr_i[ADDR_W-1:3], 3'b000};
      ram_wr_o   = lane_strobe(mem_d_addr_i[2], mem_d_wr_i);
      ram_data_o = {mem_d_data_wr_i, mem_d_data_wr_i};
    end else if (grant_i) begin
      ram_addr_o = mem_i_pc_i;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.src   = grant_d ? SRC_D : SRC_I;
    push_entry.addr2 = grant_d ? mem_d_addr_i[2] : 1'b0;
    push_entry.tag   = grant_d ? mem_d_req_tag_i : '0;
  end

  assign fifo_pop = ram_ack_i & ~fifo_empty;

  biriscv_tcm_arb_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (handshake),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Response steering back to the source recorded at the FIFO head.
  always_comb begin
    mem_i_valid_o    = 1'b0;
    mem_i_error_o    = 1'b0;
    mem_i_inst_o     = '0;
    mem_d_ack_o      = 1'b0;
    mem_d_error_o    = 1'b0;
    mem_d_data_rd_o  = '0;
    mem_d_resp_tag_o = '0;
    if (fifo_pop) begin
      if (head_entry.src == SRC_I) begin
        mem_i_valid_o = 1'b1;
        mem_i_error_o = ram_error_i;
        mem_i_inst_o  = ram_data_i;
      end else begin
        mem_d_ack_o      = 1'b1;
        mem_d_error_o    = ram_error_i;
        mem_d_data_rd_o  = head_entry.addr2 ? ram_data_i[63:32] : ram_data_i[31:0];
        mem_d_resp_tag_o = head_entry.tag;
      end
    end
  end

  // Round-robin pointer and sticky spurious-ack flag next-state.
  always_comb begin
    last_d_d   = handshake ? grant_d : last_d_q;
    spurious_d = spurious_q | (ram_ack_i & fifo_empty);
  end

  // Arbiter state; pointer resets to data-last so fetch wins the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_d_q   <= 1'b1;
      spurious_q <= 1'b0;
    end else begin
      last_d_q   <= last_d_d;
      spurious_q <= spurious_d;
    end
  end

  assign spurious_o = spurious_q;

`ifdef BIRISCV_TCM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_stall_q;

  // Free-running wrapping counters of accepted handshakes and stalled request cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_i_q     <= '0;
      perf_d_q     <= '0;
      perf_stall_q <= '0;
    end else begin
      if (mem_i_accept_o) perf_i_q <= perf_i_q + 32'd1;
      if (mem_d_accept_o) perf_d_q <= perf_d_q + 32'd1;
      if ((i_req | d_req) && !handshake) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_i_grants_o = perf_i_q;
  assign perf_d_grants_o = perf_d_q;
  assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_biriscv_tcm_arbiter.sv
// Self-checking bench for biriscv_tcm_arbiter: directed scenarios, then randomized traffic
// checked against an in-order response scoreboard.
module tb_biriscv_tcm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rd;
  logic [31:0] i_pc;
  logic        i_accept, i_valid, i_error;
  logic [63:0] i_inst;
  logic        d_rd;
  logic [3:0]  d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [10:0] d_tag;
  logic        d_accept, d_ack, d_error;
  logic [31:0] d_rdata;
  logic [10:0] d_rtag;
  logic        ram_req;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wr;
  logic [63:0] ram_wdata;
  logic        ram_accept, ram_ack, ram_error;
  logic [63:0] ram_rdata;
  logic        spurious;
`ifdef BIRISCV_TCM_ARB_PERF_EN
  logic [31:0] perf_i, perf_d, perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {bit src; bit a2; bit [10:0] tag;} resp_t;
  resp_t exp_q[$];
  bit    m_last_d;
  int    m_gi_cnt, m_gd_cnt, m_stall_cnt;

  always #5 clk = ~clk;

  biriscv_tcm_arbiter #(
    .OUTSTANDING (4),
    .ADDR_W      (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .mem_i_rd_i       (i_rd),
    .mem_i_pc_i       (i_pc),
    .mem_i_accept_o   (i_accept),
    .mem_i_valid_o    (i_valid),
    .mem_i_error_o    (i_error),
    .mem_i_inst_o     (i_inst),
    .mem_d_rd_i       (d_rd),
    .mem_d_wr_i       (d_wr),
    .mem_d_addr_i     (d_addr),
    .mem_d_data_wr_i  (d_wdata),
    .mem_d_req_tag_i  (d_tag),
    .mem_d_accept_o   (d_accept),
    .mem_d_ack_o      (d_ack),
    .mem_d_error_o    (d_error),
    .mem_d_data_rd_o  (d_rdata),
    .mem_d_resp_tag_o (d_rtag),
    .ram_req_o        (ram_req),
    .ram_addr_o       (ram_addr),
    .ram_wr_o         (ram_wr),
    .ram_data_o       (ram_wdata),
    .ram_accept_i     (ram_accept),
    .ram_ack_i        (ram_ack),
    .ram_error_i      (ram_error),
    .ram_data_i       (ram_rdata),
`ifdef BIRISCV_TCM_ARB_PERF_EN
    .perf_i_grants_o  (perf_i),
    .perf_d_grants_o  (perf_d),
    .perf_stall_o     (perf_stall),
`endif
    .spurious_o       (spurious)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_rd = 0; i_pc = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_tag = 0;
    ram_accept = 0; ram_ack = 0; ram_error = 0; ram_rdata = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    rst_n = 0;
    idle();
    #3;
    do_reset();

    // Reset state with idle inputs.
    #1;
    chk("rst_ram_req", 64'(ram_req), 0);
    chk("rst_i_valid", 64'(i_valid), 0);
    chk("rst_d_ack", 64'(d_ack), 0);
    chk("rst_spurious", 64'(spurious), 0);
    step();

    // 1: single fetch, acked next cycle.
    i_rd = 1; i_pc = 32'h8000_0008; ram_accept = 1;
    #1;
    chk("t1_req", 64'(ram_req), 1);
    chk("t1_addr", 64'(ram_addr), 64'h8000_0008);
    chk("t1_wr", 64'(ram_wr), 0);
    chk("t1_accept", 64'(i_accept), 1);
    step();
    i_rd = 0; ram_ack = 1; ram_rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("t1_valid", 64'(i_valid), 1);
    chk("t1_inst", i_inst, 64'h1111_2222_3333_4444);
    chk("t1_dack", 64'(d_ack), 0);
    step();
    idle();

    // 2: both ports request every cycle; fetch wins first, then strict alternation.
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      i_rd = (k < 4); d_rd = (k < 4); i_pc = 32'h100 + 32'(k * 8);
      d_addr = 32'h200; d_tag = 11'(11'h100 + k); ram_accept = 1;
      ram_ack = (k >= 1); ram_rdata = 64'(k) * 64'h0101_0101_0101_0101;
      #1;
      if (k < 4) begin
        chk($sformatf("t2_iacc%0d", k), 64'(i_accept), 64'((k % 2) == 0));
        chk($sformatf("t2_dacc%0d", k), 64'(d_accept), 64'((k % 2) == 1));
      end
      if (k >= 1) begin
        chk($sformatf("t2_ivld%0d", k), 64'(i_valid), 64'(((k - 1) % 2) == 0));
        chk($sformatf("t2_dack%0d", k), 64'(d_ack), 64'(((k - 1) % 2) == 1));
        if (((k - 1) % 2) == 1) chk($sformatf("t2_dtag%0d", k), 64'(d_rtag), 64'(11'h100 + k - 1));
      end
      step();
    end
    idle();

    // 3: data read from the upper word.
    d_rd = 1; d_addr = 32'h8000_0004; d_tag = 11'h5A5; ram_accept = 1;
    #1;
    chk("t3_addr", 64'(ram_addr), 64'h8000_0000);
    chk("t3_wr", 64'(ram_wr), 0);
    chk("t3_accept", 64'(d_accept), 1);
    step();
    idle();
    ram_ack = 1; ram_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("t3_ack", 64'(d_ack), 1);
    chk("t3_data", 64'(d_rdata), 64'hAAAA_BBBB);
    chk("t3_tag", 64'(d_rtag), 64'h5A5);
    step();
    idle();

    // 4: data write to the upper word.
    d_wr = 4'b0011; d_addr = 32'h8000_0004; d_wdata = 32'h1234_5678; ram_accept = 1;
    #1;
    chk("t4_wr", 64'(ram_wr), 64'h30);
    chk("t4_wdata", ram_wdata, 64'h1234_5678_1234_5678);
    step();
    idle();
    ram_ack = 1;
    #1;
    chk("t4_ack", 64'(d_ack), 1);
    step();
    idle();

    // 5: FIFO fills at 4 outstanding; one ack frees a slot, accepted the following cycle.
    do_reset();
    i_rd = 1; i_pc = 32'h40; ram_accept = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t5_acc%0d", k), 64'(i_accept), 1);
      step();
    end
    #1;
    chk("t5_full_req", 64'(ram_req), 0);
    chk("t5_full_acc", 64'(i_accept), 0);
    step();
    ram_ack = 1;
    #1;
    chk("t5_pop_acc", 64'(i_accept), 0);
    chk("t5_pop_vld", 64'(i_valid), 1);
    step();
    ram_ack = 0;
    #1;
    chk("t5_after_acc", 64'(i_accept), 1);
    step();
    i_rd = 0;
    for (int k = 0; k < 4; k++) begin
      ram_ack = 1;
      #1;
      chk($sformatf("t5_drain%0d", k), 64'(i_valid), 1);
      step();
    end
    idle();

    // 6: reset with two requests in flight; late acks are dropped and flagged.
    i_rd = 1; ram_accept = 1;
    step();
    step();
    idle();
    do_reset();
    chk("t6_spur_pre", 64'(spurious), 0);
    ram_ack = 1; ram_rdata = 64'hDEAD;
    #1;
    chk("t6_no_ivld", 64'(i_valid), 0);
    chk("t6_no_dack", 64'(d_ack), 0);
    step();
    ram_ack = 0;
    #1;
    chk("t6_spur1", 64'(spurious), 1);
    step();
    step();
    chk("t6_spur_sticky", 64'(spurious), 1);
    do_reset();
    chk("t6_spur_clr", 64'(spurious), 0);

    // Randomized traffic against the in-order response scoreboard.
    m_last_d = 1;
    m_gi_cnt = 0; m_gd_cnt = 0; m_stall_cnt = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit ireq, dreq, gi, gd, full;
      bit [3:0] wr;
      resp_t r;
      i_rd       = ($urandom % 2) == 1;
      i_pc       = {29'($urandom), 3'b000};
      d_rd       = ($urandom % 3) == 0;
      wr         = ($urandom % 3) == 0 ? 4'($urandom) : 4'b0;
      d_wr       = wr;
      d_addr     = $urandom;
      d_wdata    = $urandom;
      d_tag      = 11'($urandom);
      ram_accept = ($urandom % 4) != 0;
      ram_ack    = (exp_q.size() > 0) && (($urandom % 2) == 1);
      ram_rdata  = {$urandom, $urandom};
      ram_error  = ($urandom % 8) == 0;
      #1;
      ireq = i_rd;
      dreq = d_rd || (wr != 0);
      full = exp_q.size() >= 4;
      gi = 0; gd = 0;
      if (!full) begin
        if (ireq && dreq) begin
          if (m_last_d) gi = 1; else gd = 1;
        end else begin
          gi = ireq; gd = dreq;
        end
      end
      chk("r_req", 64'(ram_req), 64'(gi | gd));
      chk("r_iacc", 64'(i_accept), 64'(gi & ram_accept));
      chk("r_dacc", 64'(d_accept), 64'(gd & ram_accept));
      if (gi) chk("r_iaddr", 64'(ram_addr), 64'(i_pc));
      if (gd) begin
        chk("r_daddr", 64'(ram_addr), 64'(d_addr & 32'hFFFF_FFF8));
        chk("r_dwr", 64'(ram_wr), d_addr[2] ? 64'(wr) << 4 : 64'(wr));
        chk("r_dwdata", ram_wdata, {d_wdata, d_wdata});
      end
      if (ram_ack) begin
        r = exp_q[0];
        chk("r_ivld", 64'(i_valid), 64'(!r.src));
        chk("r_dack", 64'(d_ack), 64'(r.src));
        if (!r.src) begin
          chk("r_inst", i_inst, ram_rdata);
          chk("r_ierr", 64'(i_error), 64'(ram_error));
        end else begin
          chk("r_drd", 64'(d_rdata), r.a2 ? 64'(ram_rdata[63:32]) : 64'(ram_rdata[31:0]));
          chk("r_dtag", 64'(d_rtag), 64'(r.tag));
          chk("r_derr", 64'(d_error), 64'(ram_error));
        end
      end else begin
        chk("r_idle_ivld", 64'(i_valid), 0);
        chk("r_idle_dack", 64'(d_ack), 0);
      end
      @(posedge clk);
      if (ram_ack) void'(exp_q.pop_front());
      if ((gi | gd) && ram_accept) begin
        r.src = gd; r.a2 = gd ? d_addr[2] : 1'b0; r.tag = gd ? d_tag : 11'h0;
        exp_q.push_back(r);
        m_last_d = gd;
        if (gi) m_gi_cnt++; else m_gd_cnt++;
      end else if (ireq || dreq) begin
        m_stall_cnt++;
      end
      #1;
    end
`ifdef BIRISCV_TCM_ARB_PERF_EN
    chk("perf_i", 64'(perf_i), 64'(m_gi_cnt));
    chk("perf_d", 64'(perf_d), 64'(m_gd_cnt));
    chk("perf_stall", 64'(perf_stall), 64'(m_stall_cnt));
`endif
    chk("r_no_spurious", 64'(spurious), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/biriscv_tcm_arbiter.md
Name: biriscv_tcm_arbiter

Overview:
Shares one 64-bit single-ported TCM/memory port between the core's instruction-fetch port and data port.
- Arbitration: round-robin.
- Response ordering: in order, tracked by an outstanding-response FIFO that steers each response back to its source.
- Placement: between riscv_core and tcm_mem in tb_top and SoC tops.

Parameters:
OUTSTANDING, 4, max in-flight downstream requests (power of 2, ≥2)
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
mem_i_rd_i  in  1  fetch request
mem_i_pc_i  in  32  fetch address (8B aligned)
mem_i_accept_o  out  1  fetch accepted
mem_i_valid_o  out  1  fetch response valid
mem_i_error_o  out  1  fetch response error
mem_i_inst_o  out  64  fetch data
mem_d_rd_i  in  1  data read request
mem_d_wr_i  in  4  data byte write enables
mem_d_addr_i  in  32  data address
mem_d_data_wr_i  in  32  write data
mem_d_req_tag_i  in  11  request tag
mem_d_accept_o  out  1  data accepted
mem_d_ack_o  out  1  data response (reads and writes)
mem_d_error_o  out  1  data response error
mem_d_data_rd_o  out  32  read data
mem_d_resp_tag_o  out  11  returned tag
ram_req_o  out  1  downstream request
ram_addr_o  out  32  downstream address, bits[2:0]=0
ram_wr_o  out  8  downstream byte enables
ram_data_o  out  64  downstream write data
ram_accept_i  in  1  downstream accepted
ram_ack_i  in  1  downstream response
ram_error_i  in  1  downstream error
ram_data_i  in  64  downstream read data
spurious_o  out  1  sticky: ack received with FIFO empty

Behaviour:
- Reset (rst_i=0, async): all outputs 0; FIFO empty; RR pointer = data-port-last (fetch wins first tie); spurious_o=0.
- Data request present = mem_d_rd_i | (|mem_d_wr_i).
- Grant, combinational from requests, pointer and FIFO occupancy:
  - No grant while FIFO full; ram_req_o=0.
  - One requester: it wins.
  - Both requesting: the one not granted last wins.
  - Pointer updates only on handshake (ram_req_o & ram_accept_i).
- Upstream accept: mem_x_accept_o = grant_x & ram_accept_i & !fifo_full. Same cycle, FIFO pushes {src, addr[2], tag}.
- Fetch request drive: ram_addr_o=pc, ram_wr_o=0.
- Data request drive:
  - ram_addr_o = {addr[31:3],3'b0}.
  - ram_wr_o = addr[2] ? {wr,4'b0} : {4'b0,wr}.
  - ram_data_o = {data_wr,data_wr}.
- Response on ram_ack_i, combinational, FIFO pops:
  - src=I: mem_i_valid_o=1, mem_i_inst_o=ram_data_i, mem_i_error_o=ram_error_i.
  - src=D: mem_d_ack_o=1, mem_d_data_rd_o = addr2 ? ram_data_i[63:32] : ram_data_i[31:0], mem_d_resp_tag_o=tag, mem_d_error_o=ram_error_i.
- Downstream returns responses in order, minimum one cycle after accept; a same-cycle ack is not supported.
- Push and pop in the same cycle: allowed when full, because the pop frees the slot. Accept is still gated by pre-pop full for timing; that costs one bubble and is acceptable.
- ram_ack_i with FIFO empty: response dropped, no upstream output, spurious_o set until reset.
- Reset mid-operation: in-flight entries discarded. Late downstream acks then set spurious_o; the bench must tolerate this.
- Pointer wrap: FIFO uses log2(OUTSTANDING)+1-bit pointers; full/empty taken from the MSB compare.

Optional Feature:
- Macro BIRISCV_TCM_ARB_PERF_EN.
- When defined, adds outputs perf_i_grants_o[31:0], perf_d_grants_o[31:0], perf_stall_o[31:0]:
  - grant counters count accepted handshakes per source;
  - perf_stall_o counts cycles with any request present and no accept.
- All counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Shared package biriscv_tcm_arb_pkg: SRC_I=1'b0/SRC_D=1'b1, tag width 11, FIFO entry typedef {src, addr2, tag[10:0]}.
- One sub-module: biriscv_tcm_arb_fifo (sync FIFO, DEPTH=OUTSTANDING, async active-low reset, full/empty/push/pop).

Test Plan:
1. Fetch only, pc=0x8000_0008, ram_accept_i=1, ack next cycle with data 0x1111_2222_3333_4444 -> mem_i_valid_o=1 with that data; mem_d_ack_o=0.
2. Simultaneous I and D read every cycle, ram_accept_i=1 -> grants alternate I,D,I,D starting with I; responses steered in issue order.
3. D read addr=0x8000_0004, tag=0x5A5, ack data 0xAAAA_BBBB_CCCC_DDDD -> mem_d_data_rd_o=0xAAAA_BBBB, resp_tag=0x5A5.
4. D write addr=...4, wr=4'b0011, data=0x1234_5678 -> ram_wr_o=8'h30, ram_data_o=0x1234_5678_1234_5678; ack -> mem_d_ack_o=1.
5. Withhold ram_ack_i after 4 accepts (OUTSTANDING=4) -> 5th request not accepted, ram_req_o=0; one ack -> 5th accepted the following cycle.
6. rst_i low with 2 in flight, release, then inject ram_ack_i -> no upstream valid/ack, spurious_o=1 until next reset.
